led_pio_sequencer: RTL

//  Autonomous pattern controller for the 8-bit LED PIO slave. CPU configures mode/period/pattern via a

---
 rtl/led_pio_sequencer_if.sv | 30 +++
 rtl/led_pio_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pio_sequencer_if.sv
// Avalon-MM style bus bundle: the CSR port (sequencer is slave) and the write-only PIO port (sequencer is master).
// The master modport carries no readdata because the PIO side is write-only.
interface led_pio_sequencer_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              waitrequest;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  waitrequest
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata,
        output waitrequest
    );
endinterface

// File: rtl/led_pio_sequencer.sv
// LED pattern sequencer: CSR slave sets mode/period/pattern, a prescaled tick steps the pattern, and a write master pushes it to the PIO.
// Latency: one clock from a pattern update to the PIO strobe. Backpressure: the strobe holds under waitrequest; updates made meanwhile coalesce into one follow-up write.
module led_pio_sequencer #(
    parameter int                   DATA_W     = 8,
    parameter int                   PRESC_W    = 24,
    parameter logic [PRESC_W-1:0]   PERIOD_RST = 24'd5000000,
    parameter logic [DATA_W-1:0]    PAT_RST    = 8'h01
) (
    input  logic              clk,
    input  logic              reset_n,
    led_pio_sequencer_if.slave  s_csr,
    led_pio_sequencer_if.master m_pio
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_STATIC = 2'b00;
    localparam logic [1:0] MODE_ROTATE = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_BLINK  = 2'b11;

    localparam logic [PRESC_W-1:0] PRESC_ONE = 1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_enable;
    logic [1:0]          r_mode;
    logic [PRESC_W-1:0]  r_period;
    logic [PRESC_W-1:0]  r_presc;
    logic [DATA_W-1:0]   r_pattern;
    logic                r_dir;
    logic                r_phase;
    logic [15:0]         r_steps;
    logic [15:0]         r_step_cnt;
    logic                r_pending;
    logic                r_m_cs;
    logic                r_m_wr_n;
    logic [DATA_W-1:0]   r_m_dat;

    logic                w_wr;
    logic                w_wr_ctrl;
    logic                w_wr_period;
    logic                w_wr_pat;
    logic                w_wr_steps;
    logic [PRESC_W-1:0]  w_presc_last;
    logic                w_counting;
    logic                w_tick;
    logic                w_step;
    logic [15:0]         w_cnt_inc;
    logic                w_limit_hit;
    logic                w_done;
    logic [DATA_W-1:0]   w_pat_nxt;
    logic                w_dir_nxt;
    logic                w_phase_nxt;
    logic                w_update;
    logic [DATA_W-1:0]   w_disp;
    logic                w_m_free;
    logic                w_launch;
    logic [31:0]         w_rdata;
    logic                w_unused;

    // CSR decode
    assign w_wr        = s_csr.chipselect & ~s_csr.write_n;
    assign w_wr_ctrl   = w_wr & (s_csr.address == 2'd0);
    assign w_wr_period = w_wr & (s_csr.address == 2'd1);
    assign w_wr_pat    = w_wr & (s_csr.address == 2'd2);
    assign w_wr_steps  = w_wr & (s_csr.address == 2'd3);

    // Bits above the widest CSR field are ignored.
    assign w_unused = ^s_csr.writedata;

    // PERIOD of zero behaves as one; >= keeps a shrunk PERIOD from running the counter past its wrap point.
    assign w_presc_last = (r_period == '0) ? '0 : (r_period - PRESC_ONE);
    assign w_counting   = (r_state == ST_RUN) && (r_mode != MODE_STATIC);
    assign w_tick       = w_counting && (r_presc >= w_presc_last);
    assign w_step       = w_tick && !w_wr_pat;
    assign w_cnt_inc    = (r_step_cnt == 16'hFFFF) ? r_step_cnt : (r_step_cnt + 16'd1);
    assign w_limit_hit  = w_step && !w_wr_steps && (r_steps != 16'd0) && (w_cnt_inc >= r_steps);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_wr_ctrl && s_csr.writedata[0]) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_wr_ctrl && !s_csr.writedata[0]) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_limit_hit) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done = 1'b1;
                if (w_wr_ctrl) begin
                    w_state_nxt = s_csr.writedata[0] ? ST_RUN : ST_IDLE;
                end else if (w_wr_steps) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_enable <= 1'b0;
            r_mode   <= MODE_STATIC;
            r_period <= PERIOD_RST;
        end else begin
            if (w_wr_ctrl) begin
                r_enable <= s_csr.writedata[0];
                r_mode   <= s_csr.writedata[2:1];
            end
            if (w_wr_period) begin
                r_period <= s_csr.writedata[PRESC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_steps    <= 16'd0;
            r_step_cnt <= 16'd0;
        end else if (w_wr_steps) begin
            r_steps    <= s_csr.writedata[15:0];
            r_step_cnt <= 16'd0;
        end else if (w_step) begin
            r_step_cnt <= w_cnt_inc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
        end else if (w_wr_pat || !w_counting || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PRESC_ONE;
        end
    end

    // A CPU pattern write overrides a coincident tick, which is simply lost.
    always_comb begin
        w_pat_nxt   = r_pattern;
        w_dir_nxt   = r_dir;
        w_phase_nxt = r_phase;
        w_update    = 1'b0;
        if (w_wr_pat) begin
            w_pat_nxt   = s_csr.writedata[DATA_W-1:0];
            w_dir_nxt   = 1'b0;
            w_phase_nxt = 1'b0;
            w_update    = 1'b1;
        end else if (w_step) begin
            w_update = 1'b1;
            case (r_mode)
                MODE_ROTATE: w_pat_nxt = {r_pattern[DATA_W-2:0], r_pattern[DATA_W-1]};
                MODE_BOUNCE: begin
                    if (!r_dir) begin
                        if (r_pattern[DATA_W-1]) begin
                            w_dir_nxt = 1'b1;
                            w_pat_nxt = r_pattern >> 1;
                        end else begin
                            w_pat_nxt = r_pattern << 1;
                        end
                    end else begin
                        if (r_pattern[0]) begin
                            w_dir_nxt = 1'b0;
                            w_pat_nxt = r_pattern << 1;
                        end else begin
                            w_pat_nxt = r_pattern >> 1;
                        end
                    end
                end
                MODE_BLINK:  w_phase_nxt = ~r_phase;
                default:     w_pat_nxt = r_pattern;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pattern <= PAT_RST;
            r_dir     <= 1'b0;
            r_phase   <= 1'b0;
        end else begin
            r_pattern <= w_pat_nxt;
            r_dir     <= w_dir_nxt;
            r_phase   <= w_phase_nxt;
        end
    end

    assign w_disp = ((r_mode == MODE_BLINK) && r_phase) ? '0 : r_pattern;

    // The master is free when idle or when the held strobe is accepted this cycle.
    assign w_m_free = !r_m_cs || !m_pio.waitrequest;
    assign w_launch = r_pending && w_m_free;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= 1'b0;
            r_m_cs    <= 1'b0;
            r_m_wr_n  <= 1'b1;
            r_m_dat   <= '0;
        end else begin
            r_pending <= w_update | (r_pending & ~w_launch);
            if (w_m_free) begin
                r_m_cs   <= r_pending;
                r_m_wr_n <= ~r_pending;
                if (r_pending) begin
                    r_m_dat <= w_disp;
                end
            end
        end
    end

    assign m_pio.address    = 2'd0;
    assign m_pio.chipselect = r_m_cs;
    assign m_pio.write_n    = r_m_wr_n;
    assign m_pio.writedata  = 32'(r_m_dat);

    always_comb begin
        w_rdata = 32'd0;
        case (s_csr.address)
            2'd0:    w_rdata = {22'd0, (r_pending | r_m_cs), w_done, 5'd0, r_mode, r_enable};
            2'd1:    w_rdata = 32'(r_period);
            2'd2:    w_rdata = 32'(r_pattern);
            default: w_rdata = {16'd0, r_step_cnt};
        endcase
    end

    assign s_csr.readdata    = w_rdata;
    assign s_csr.waitrequest = 1'b0;

endmodule
